// File: rtl/alu_lane_sequencer.sv
// rtl/alu_lane_sequencer.sv - splits a full-warp ALU request into lane-sized packets
module alu_lane_sequencer #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 1,
  parameter int XLEN        = 32,
  parameter int META_W      = 64,
  localparam int NUM_PARTS  = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH  = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1,
  localparam int LANE_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  input  logic [META_W-1:0]           in_meta,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
  output logic [META_W-1:0]           out_meta,
  output logic [PID_WIDTH-1:0]        out_pid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [LANE_WIDTH-1:0]       out_tid
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                      state;
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [META_W-1:0]           meta_q;
  logic [NUM_PARTS-1:0]        pending;
  logic                        sop_flag;

  logic [NUM_PARTS-1:0] cur_onehot;
  logic [NUM_PARTS-1:0] load_vec;
  logic [PID_WIDTH-1:0] cur_pid;
  logic                 last_part;
  logic                 in_hs, out_hs;

  // Lowest pending partition is the packet on the bus; exactly one bit left marks the last.
  assign cur_onehot = pending & (~pending + NUM_PARTS'(1));
  assign last_part  = (pending & (pending - NUM_PARTS'(1))) == '0;

  assign out_valid = (state == ISSUE);
  assign out_sop   = out_valid & sop_flag;
  assign out_eop   = out_valid & last_part;
  assign out_pid   = cur_pid;
  assign out_meta  = meta_q;

  assign in_ready = ~reset & ((state == IDLE) | (out_valid & out_ready & out_eop));
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  always_comb begin
    cur_pid = '0;
    for (int p = NUM_PARTS - 1; p >= 0; p--) begin
      if (pending[p]) cur_pid = PID_WIDTH'(p);
    end

    load_vec = '0;
    for (int p = 0; p < NUM_PARTS; p++) begin
      load_vec[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
    end
    // An empty warp still emits one packet so commit accounting stays balanced.
    if (in_tmask == '0) load_vec = NUM_PARTS'(1);

    out_tmask    = '0;
    out_rs1_data = '0;
    out_rs2_data = '0;
    out_rs3_data = '0;
    for (int p = 0; p < NUM_PARTS; p++) begin
      if (cur_onehot[p]) begin
        out_tmask    = tmask_q[p*NUM_LANES +: NUM_LANES];
        out_rs1_data = rs1_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        out_rs2_data = rs2_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        out_rs3_data = rs3_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
      end
    end

    out_tid = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (out_tmask[l]) out_tid = LANE_WIDTH'(l);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      sop_flag <= 1'b1;
    end else if (in_hs) begin
      state    <= ISSUE;
      pending  <= load_vec;
      sop_flag <= 1'b1;
      tmask_q  <= in_tmask;
      rs1_q    <= in_rs1_data;
      rs2_q    <= in_rs2_data;
      rs3_q    <= in_rs3_data;
      meta_q   <= in_meta;
    end else if (out_hs) begin
      pending  <= pending & ~cur_onehot;
      sop_flag <= 1'b0;
      if (last_part) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// tb/tb_alu_lane_sequencer.sv - randomized and directed checks against a packet-queue model
module tb_alu_lane_sequencer;
  localparam int NT = 8;
  localparam int NL = 2;
  localparam int XL = 32;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [NT-1:0] in_tmask;
  logic [NT*XL-1:0] in_rs1_data, in_rs2_data, in_rs3_data;
  logic [MW-1:0] in_meta;
  logic out_valid, out_ready;
  logic [NL-1:0] out_tmask;
  logic [NL*XL-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
  logic [MW-1:0] out_meta;
  logic [1:0] out_pid;
  logic out_sop, out_eop;
  logic [0:0] out_tid;

  alu_lane_sequencer #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .META_W(MW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
    .in_meta(in_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_tmask(out_tmask),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
    .out_meta(out_meta), .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop),
    .out_tid(out_tid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pid;
    logic [1:0]  tmask;
    logic [63:0] rs1, rs2, rs3, meta;
    logic        sop, eop;
    logic [0:0]  tid;
  } pkt_t;

  pkt_t q[$];
  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected packets: one per non-empty lane pair, in ascending partition order.
  task automatic push_warp();
    int parts[$];
    pkt_t e;
    for (int p = 0; p < NT / NL; p++)
      if (in_tmask[p*NL +: NL] != 0) parts.push_back(p);
    if (parts.size() == 0) parts.push_back(0);
    for (int i = 0; i < parts.size(); i++) begin
      int p = parts[i];
      e.pid   = 2'(p);
      e.tmask = in_tmask[p*NL +: NL];
      e.rs1   = in_rs1_data[p*NL*XL +: NL*XL];
      e.rs2   = in_rs2_data[p*NL*XL +: NL*XL];
      e.rs3   = in_rs3_data[p*NL*XL +: NL*XL];
      e.meta  = in_meta;
      e.sop   = (i == 0);
      e.eop   = (i == parts.size() - 1);
      e.tid   = (e.tmask[0] == 1'b0 && e.tmask[1] == 1'b1) ? 1'b1 : 1'b0;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", 64'(in_ready),
          64'(!reset && (q.size() == 0 || (q.size() == 1 && out_ready))));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("pid", 64'(out_pid), 64'(q[0].pid));
        chk("tmask", 64'(out_tmask), 64'(q[0].tmask));
        chk("rs1", out_rs1_data, q[0].rs1);
        chk("rs2", out_rs2_data, q[0].rs2);
        chk("rs3", out_rs3_data, q[0].rs3);
        chk("meta", out_meta, q[0].meta);
        chk("sop", 64'(out_sop), 64'(q[0].sop));
        chk("eop", 64'(out_eop), 64'(q[0].eop));
        chk("tid", 64'(out_tid), 64'(q[0].tid));
      end
    end
    if (reset) q.delete();
    else begin
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) push_warp();
    end
  end

  task automatic set_warp(input logic [7:0] m, input logic [31:0] base);
    in_tmask = m;
    for (int t = 0; t < NT; t++) begin
      in_rs1_data[t*XL +: XL] = base + 32'(t);
      in_rs2_data[t*XL +: XL] = $urandom;
      in_rs3_data[t*XL +: XL] = $urandom;
    end
    in_meta = {$urandom, $urandom};
  endtask

  // Returns 1ns after the accepting edge, so the next negedge shows the first packet.
  task automatic send(input logic [7:0] m, input logic [31:0] base);
    int n = 0;
    set_warp(m, base);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_warp(8'h00, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_sop", 64'(out_sop), 64'(0));
    chk("rst_eop", 64'(out_eop), 64'(0));
    chk("rst_pid", 64'(out_pid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Full warp
    send(8'hFF, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_valid", 64'(out_valid), 64'(1));
      chk("full_pid", 64'(out_pid), 64'(k));
      chk("full_tmask", 64'(out_tmask), 64'(2'b11));
      chk("full_sop", 64'(out_sop), 64'(k == 0));
      chk("full_eop", 64'(out_eop), 64'(k == 3));
      chk("full_tid", 64'(out_tid), 64'(0));
      if (k == 2) chk("full_rs1_p2", out_rs1_data, {32'd6, 32'd5});
    end
    @(negedge clk);
    chk("full_done", 64'(out_valid), 64'(0));

    // Single partition
    send(8'h30, 32'd100);
    @(negedge clk);
    chk("single_pid", 64'(out_pid), 64'(2));
    chk("single_tmask", 64'(out_tmask), 64'(2'b11));
    chk("single_sopeop", 64'({out_sop, out_eop}), 64'(2'b11));
    @(negedge clk);
    chk("single_idle_valid", 64'(out_valid), 64'(0));
    chk("single_idle_ready", 64'(in_ready), 64'(1));

    // Sparse warp
    send(8'h84, 32'd200);
    @(negedge clk);
    chk("sparse0", 64'({out_pid, out_tmask, out_tid, out_sop, out_eop}), 64'({2'd1, 2'b01, 1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    chk("sparse1", 64'({out_pid, out_tmask, out_tid, out_sop, out_eop}), 64'({2'd3, 2'b10, 1'b1, 1'b0, 1'b1}));

    // Empty mask
    send(8'h00, 32'd300);
    @(negedge clk);
    chk("empty", 64'({out_valid, out_pid, out_tmask, out_tid, out_sop, out_eop}), 64'({1'b1, 2'd0, 2'b00, 1'b0, 1'b1, 1'b1}));
    @(negedge clk);
    chk("empty_done", 64'(out_valid), 64'(0));

    // Backpressure on pid 1, then a back-to-back warp
    send(8'hFF, 32'd400);
    @(negedge clk);
    chk("bp_pid0", 64'(out_pid), 64'(0));
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold", 64'({out_valid, out_pid}), 64'({1'b1, 2'd1}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_warp(8'h03, 32'd500);
    in_valid = 1'b1;
    @(negedge clk); chk("bp_pid1", 64'(out_pid), 64'(1));
    @(negedge clk); chk("bp_pid2", 64'(out_pid), 64'(2));
    @(negedge clk);
    chk("bp_pid3", 64'(out_pid), 64'(3));
    chk("b2b_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_next", 64'({out_valid, out_pid, out_tmask, out_sop, out_eop}), 64'({1'b1, 2'd0, 2'b11, 1'b1, 1'b1}));

    // Reset mid-warp
    send(8'hFF, 32'd600);
    @(negedge clk);
    @(negedge clk);
    chk("rmw_pid1", 64'(out_pid), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("rmw_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rmw_valid", 64'(out_valid), 64'(0));
    chk("rmw_ready", 64'(in_ready), 64'(1));
    send(8'h0C, 32'd700);
    @(negedge clk);
    chk("rmw_new", 64'({out_valid, out_pid, out_sop, out_eop}), 64'({1'b1, 2'd1, 1'b1, 1'b1}));

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      int r;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9);
      set_warp((r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom), $urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_lane_sequencer.md
# alu_lane_sequencer

Front-end sequencer for the integer ALU lane block. It accepts one full-warp ALU request (`NUM_THREADS` threads) per handshake. It issues that request to the `NUM_LANES`-wide ALU as one packet per non-empty thread partition, tagging each packet with `pid`, `sop`, `eop` and the branch lane index `tid`. It sits between the ALU dispatch queue and the integer unit's execute input, so the int unit only ever sees lane-sized packets.

## Interface
- `NUM_THREADS`, default 4: threads per warp; must be a multiple of `NUM_LANES`.
- `NUM_LANES`, default 1: ALU lane count.
- `XLEN`, default 32: operand width.
- `META_W`, default 64: opaque per-warp payload (uuid, wid, rd, wb, op_type, op_mod, PC, imm, use_PC, use_imm); passed through unchanged.
- Derived: `NUM_PARTS = NUM_THREADS/NUM_LANES`, `PID_WIDTH = UP(CLOG2(NUM_PARTS))`, `LANE_WIDTH = UP(CLOG2(NUM_LANES))`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: warp request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `in_tmask` in `NUM_THREADS`: active-thread mask.
- `in_rs1_data` in `NUM_THREADS*XLEN`: operand 1, thread `t` at bits `[t*XLEN +: XLEN]`.
- `in_rs2_data` in `NUM_THREADS*XLEN`: operand 2.
- `in_rs3_data` in `NUM_THREADS*XLEN`: operand 3, forwarded.
- `in_meta` in `META_W`: payload.
- `out_valid` out 1: packet valid.
- `out_ready` in 1: int unit ready.
- `out_tmask` out `NUM_LANES`: packet lane mask.
- `out_rs1_data`, `out_rs2_data`, `out_rs3_data` out `NUM_LANES*XLEN` each: packet operands.
- `out_meta` out `META_W`: payload copy.
- `out_pid` out `PID_WIDTH`: partition index.
- `out_sop` out 1: first packet of warp.
- `out_eop` out 1: last packet of warp.
- `out_tid` out `LANE_WIDTH`: lowest set bit of `out_tmask`, or 0 if `out_tmask` is 0.

## Operation
- Partition `p` covers threads `[p*NUM_LANES +: NUM_LANES]`. A partition is non-empty if any of its tmask bits are set.
- States:
  - IDLE: nothing held; `in_ready=1`.
  - ISSUE: warp latched in a capture register (tmask, all operands, meta); `out_valid=1`.
- IDLE → ISSUE on input handshake. The capture register loads, and `pending` (`NUM_PARTS` bits) loads with the non-empty partition vector.
- In ISSUE, the current packet is the lowest set bit of `pending`:
  - `out_pid` = that index.
  - `out_tmask`/operands are that slice.
  - `out_sop` = 1 until the first output handshake of the warp.
  - `out_eop` = 1 when `pending` has exactly one bit set.
- On output handshake, clear the current bit. If it was `eop`:
  - with a simultaneous input handshake, stay in ISSUE with the new warp;
  - otherwise go to IDLE.
- `in_ready = (state==IDLE) | (out_valid & out_ready & out_eop)`. Back-to-back warps issue with no bubble.
- All-zero `in_tmask`: `pending` is forced to `1`. One packet is emitted with pid 0, `out_tmask=0`, `sop=eop=1`, `tid=0`, so commit and retirement accounting stays balanced.
- `NUM_PARTS==1`: every warp is exactly one packet with pid 0 and `sop=eop=1`. `pending`/pid logic reduces to constants.
- Empty partitions are never emitted, except for the all-zero case above.

## Timing
- Latency: input handshake at cycle T gives the first packet `out_valid` at T+1. Warp throughput is one packet per cycle while `out_ready=1`.
- A warp with k non-empty partitions occupies exactly k output handshakes.
- While `out_valid & ~out_ready`, all `out_*` hold stable and `pending` does not change.
- `out_*` are driven from registers and the `pending` priority mux only, with no combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready`.
- Reset, including mid-warp: on the cycle after `reset` is sampled high:
  - state=IDLE, `out_valid=0`, `pending=0`, `sop` flag=1;
  - the held warp is discarded;
  - `in_ready=0` while `reset=1`, and 1 the cycle after deassertion.
- Data outputs are don't-care while `out_valid=0`. The control outputs `out_sop`, `out_eop` and `out_pid` reset to 0.

## Test plan
All scenarios use `NUM_THREADS=8`, `NUM_LANES=2`, `XLEN=32`.
- **Full warp:** `in_tmask=0xFF`, rs1 thread t = t+1, `out_ready=1` → 4 packets on consecutive cycles T+1..T+4:
  - pid 0,1,2,3, each `out_tmask=2'b11`;
  - pid 2 `out_rs1_data={32'd6,32'd5}`;
  - `sop` only on pid 0, `eop` only on pid 3, `tid=0`.
- **Single partition:** `in_tmask=0x30` → one packet: pid 2, tmask `11`, `sop=eop=1`, `tid=0`, at T+1. IDLE at T+2.
- **Sparse warp:** `in_tmask=0x84` → packet pid 1, tmask `01`, `tid=0`, `sop=1`, `eop=0`; then pid 3, tmask `10`, `tid=1`, `sop=0`, `eop=1`.
- **Backpressure and back-to-back:**
  - `in_tmask=0xFF`, `out_ready=0` for 3 cycles during pid 1 → pid 1 held stable; sequence 0,1,2,3 with no duplicates or drops.
  - Second warp `0x03` presented throughout → accepted in the pid-3 handshake cycle; its pid 0 packet appears the next cycle.
- **Empty mask:** `in_tmask=0x00` → exactly one packet: pid 0, `out_tmask=00`, `sop=eop=1`.
- **Reset mid-warp:** `reset` pulsed after pid 1 is accepted → `out_valid=0` the next cycle; no pid 2 or 3 emitted; a new warp is accepted normally after reset is released.
